// File: rtl/pool_frame_ctrl.sv
// Frame sequencer for the 2x2 pool/ReLU stage: streams a WxH feature map out of the
// feature buffer, then collects the pooler results into the result buffer.
// Optional drain watchdog enabled by defining POOL_CTRL_WATCHDOG_EN.
module pool_frame_ctrl #(
  parameter int In_d_W  = 32,
  parameter int W       = 26,
  parameter int H       = 6,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iBaseRd,
  input  logic [ADDR_W-1:0] iBaseWr,
  input  logic              iHold,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oRdAddr,
  output logic [3:0]        oValid4,
  input  logic [3:0]        iPoolValid,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);

  localparam int N_OUT = (W / 2) * (H / 2);
  localparam int COL_W = $clog2(W);
  localparam int ROW_W = $clog2(H);
  localparam int K_W   = $clog2(N_OUT + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);
  localparam logic [K_W-1:0]   K_FULL   = K_W'(N_OUT);

`ifdef POOL_CTRL_WATCHDOG_EN
  typedef enum logic [2:0] {IDLE, FEED, DRAIN, DONE, ERR} state_t;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wdCnt;
`else
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
`endif

  state_t state, nextState;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W-1:0] baseWr;
  logic [K_W-1:0]    kCnt;
  logic              issue;
  logic              accept;
  logic              lastPix;

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  // DRAIN waits for the final write strobe to retire before declaring the frame done
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (iStart) nextState = FEED;
      FEED:  if (issue && lastPix) nextState = DRAIN;
      DRAIN: begin
        if (kCnt == K_FULL && !oWrEn) nextState = DONE;
`ifdef POOL_CTRL_WATCHDOG_EN
        else if (!accept && wdCnt == WD_LAST) nextState = ERR;
`endif
      end
      DONE:  nextState = IDLE;
`ifdef POOL_CTRL_WATCHDOG_EN
      ERR:   nextState = IDLE;
`endif
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    issue   = (state == FEED) && !iHold;
    accept  = ((state == FEED) || (state == DRAIN)) && (iPoolValid == 4'b1111);
    lastPix = (row == ROW_LAST) && (col == COL_LAST);
  end

  assign oBusy = (state != IDLE);

  // Read pointer walks the raster linearly so no row*W multiply is needed
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oRdEn   <= 1'b0;
      oRdAddr <= '0;
      oValid4 <= 4'b0000;
      oWrEn   <= 1'b0;
      oWrAddr <= '0;
      oDone   <= 1'b0;
      rdPtr   <= '0;
      baseWr  <= '0;
      row     <= '0;
      col     <= '0;
      kCnt    <= '0;
    end else begin
      oRdEn   <= issue;
      oValid4 <= {4{oRdEn}};
      oWrEn   <= accept;
      oDone   <= (nextState == DONE);
      if (state == IDLE && iStart) begin
        rdPtr  <= iBaseRd;
        baseWr <= iBaseWr;
        row    <= '0;
        col    <= '0;
        kCnt   <= '0;
      end
      if (issue) begin
        oRdAddr <= rdPtr;
        rdPtr   <= rdPtr + 1'b1;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (accept) begin
        oWrAddr <= baseWr + ADDR_W'(kCnt);
        kCnt    <= kCnt + 1'b1;
      end
    end
  end

`ifdef POOL_CTRL_WATCHDOG_EN
  // Idle-cycle counter restarts on every accepted result and whenever DRAIN is left
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wdCnt <= '0;
      oErr  <= 1'b0;
    end else begin
      oErr <= (nextState == ERR);
      if (state != DRAIN || accept) wdCnt <= '0;
      else                          wdCnt <= wdCnt + 1'b1;
    end
  end
`else
  assign oErr = 1'b0;
`endif

endmodule

// File: tb/tb_pool_frame_ctrl.sv
// Scoreboard bench for pool_frame_ctrl: a frame-level reference fills address queues,
// a negedge monitor pops them as the controller strobes reads and writes.
module tb_pool_frame_ctrl;

  localparam int W       = 26;
  localparam int H       = 6;
  localparam int AW      = 10;
  localparam int TIMEOUT = 64;
  localparam int N_PIX   = W * H;
  localparam int N_OUT   = (W / 2) * (H / 2);

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic [AW-1:0] iBaseRd;
  logic [AW-1:0] iBaseWr;
  logic          iHold = 1'b0;
  logic          oRdEn;
  logic [AW-1:0] oRdAddr;
  logic [3:0]    oValid4;
  logic [3:0]    iPoolValid = 4'b0000;
  logic          oWrEn;
  logic [AW-1:0] oWrAddr;
  logic          oBusy;
  logic          oDone;
  logic          oErr;

  logic [AW-1:0] rdQ[$];
  logic [AW-1:0] wrQ[$];
  int tests = 0;
  int fails = 0;
  int readCount = 0;
  int wrCount = 0;
  int doneCount = 0;
  int errCount = 0;
  int rdStart = 0;
  int wrStart = 0;
  int expWrites = 0;
  int holdMode = 0;
  int stopAfter = -1;
  int cyc = 0;
  int poolPix = 0;
  int poolOuts = 0;
  int pr, pc;
  bit junkEn = 1'b0;
  bit monOn = 1'b0;
  bit frameActive = 1'b0;
  bit prevRdEn = 1'b0;
  bit holdAtEdge = 1'b0;
  bit rstAtEdge = 1'b1;
  logic [AW-1:0] expAddr;

  pool_frame_ctrl #(
    .In_d_W(32), .W(W), .H(H), .ADDR_W(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iBaseRd(iBaseRd), .iBaseWr(iBaseWr),
    .iHold(iHold), .oRdEn(oRdEn), .oRdAddr(oRdAddr), .oValid4(oValid4),
    .iPoolValid(iPoolValid), .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oBusy(oBusy),
    .oDone(oDone), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(posedge iClk) begin
    holdAtEdge <= iHold;
    rstAtEdge  <= iRst;
  end

  // Hold pattern generator: off, every third cycle, or random
  always @(negedge iClk) begin
    cyc++;
    case (holdMode)
      1:       iHold = (cyc % 3 == 0);
      2:       iHold = ($urandom_range(0, 1) == 1);
      default: iHold = 1'b0;
    endcase
  end

  // Behavioural pooler: one full-valid result each time a 2x2 block's last pixel arrives
  always @(negedge iClk) begin
    iPoolValid = 4'b0000;
    if (iRst) begin
      poolPix  = 0;
      poolOuts = 0;
    end else begin
      if (oValid4 == 4'b1111) begin
        if (poolPix == 0) poolOuts = 0;
        pr = poolPix / W;
        pc = poolPix % W;
        poolPix = (poolPix + 1) % N_PIX;
        if ((pr % 2 == 1) && (pc % 2 == 1) && (stopAfter < 0 || poolOuts < stopAfter)) begin
          iPoolValid = 4'b1111;
          poolOuts++;
        end
      end
      if (iPoolValid == 4'b0000 && junkEn && $urandom_range(0, 3) == 0) iPoolValid = 4'b0111;
    end
  end

  // Monitor: pops expected addresses whenever the controller strobes a buffer access
  always @(negedge iClk) begin
    if (monOn) begin
      if (oRdEn) begin
        if (rdQ.size() == 0) checkOutput("rd_unexpected", 32'd1, 32'd0);
        else begin
          expAddr = rdQ.pop_front();
          checkOutput("rd_addr", 32'(oRdAddr), 32'(expAddr));
        end
        readCount++;
      end
      checkOutput("hold_no_read", 32'(holdAtEdge & oRdEn), 32'd0);
      checkOutput("valid4_lag", 32'(oValid4), (!rstAtEdge && prevRdEn) ? 32'hF : 32'h0);
      if (oWrEn) begin
        if (wrQ.size() == 0) checkOutput("wr_unexpected", 32'(oWrAddr), 32'hFFFF);
        else begin
          expAddr = wrQ.pop_front();
          checkOutput("wr_addr", 32'(oWrAddr), 32'(expAddr));
        end
        wrCount++;
      end
      if (oDone) begin
        checkOutput("done_frame_complete",
                    {29'd0, frameActive, rdQ.size() == 0, wrQ.size() == 0}, 32'd7);
        doneCount++;
        frameActive = 1'b0;
      end
      if (oErr) errCount++;
    end
    prevRdEn = oRdEn;
  end

  task automatic applyStimulus(input logic [AW-1:0] bRd, input logic [AW-1:0] bWr, input int nOut);
    @(negedge iClk);
    iStart  = 1'b1;
    iBaseRd = bRd;
    iBaseWr = bWr;
    for (int i = 0; i < N_PIX; i++) rdQ.push_back(AW'(32'(bRd) + i));
    for (int j = 0; j < nOut; j++) wrQ.push_back(AW'(32'(bWr) + j));
    rdStart     = readCount;
    wrStart     = wrCount;
    expWrites   = nOut;
    frameActive = 1'b1;
    @(negedge iClk);
    iStart  = 1'b0;
    iBaseRd = AW'($urandom_range(0, 1023));
    iBaseWr = AW'($urandom_range(0, 1023));
    checkOutput("busy_after_start", 32'(oBusy), 32'd1);
  endtask

  task automatic waitDone(input string name);
    int n;
    int d0;
    n  = 0;
    d0 = doneCount;
    while (doneCount == d0 && n < 2000) begin
      @(negedge iClk);
      n++;
    end
    checkOutput({name, "_done_seen"}, 32'(doneCount - d0), 32'd1);
    @(negedge iClk);
    checkOutput({name, "_idle_after_done"}, {30'd0, oBusy, oDone}, 32'd0);
    checkOutput({name, "_read_count"}, 32'(readCount - rdStart), 32'(N_PIX));
    checkOutput({name, "_write_count"}, 32'(wrCount - wrStart), 32'(expWrites));
  endtask

  task automatic doReset(input bit withStart);
    @(negedge iClk);
    iRst    = 1'b1;
    iStart  = withStart;
    iBaseRd = 10'd500;
    @(posedge iClk);
    #1;
    rdQ.delete();
    wrQ.delete();
    frameActive = 1'b0;
    checkOutput("rst_rdEn", 32'(oRdEn), 32'd0);
    checkOutput("rst_rdAddr", 32'(oRdAddr), 32'd0);
    checkOutput("rst_valid4", 32'(oValid4), 32'd0);
    checkOutput("rst_wrEn", 32'(oWrEn), 32'd0);
    checkOutput("rst_wrAddr", 32'(oWrAddr), 32'd0);
    checkOutput("rst_busy", 32'(oBusy), 32'd0);
    checkOutput("rst_done", 32'(oDone), 32'd0);
    checkOutput("rst_err", 32'(oErr), 32'd0);
    @(negedge iClk);
    @(negedge iClk);
    iRst   = 1'b0;
    iStart = 1'b0;
    checkOutput("idle_after_reset", 32'(oBusy), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    int e0;
    iRst    = 1'b1;
    iStart  = 1'b0;
    iBaseRd = '0;
    iBaseWr = '0;
    repeat (3) @(negedge iClk);
    checkOutput("init_rdEn", 32'(oRdEn), 32'd0);
    checkOutput("init_valid4", 32'(oValid4), 32'd0);
    checkOutput("init_wrEn", 32'(oWrEn), 32'd0);
    checkOutput("init_busy_done_err", {29'd0, oBusy, oDone, oErr}, 32'd0);
    checkOutput("init_addrs", {12'd0, oRdAddr, oWrAddr}, 32'd0);
    iRst  = 1'b0;
    monOn = 1'b1;
    @(negedge iClk);

    $display("[TB] basic frame, base 0 -> 100");
    applyStimulus(10'd0, 10'd100, N_OUT);
    waitDone("basic");

    $display("[TB] hold every third cycle");
    holdMode = 1;
    applyStimulus(10'd0, 10'd100, N_OUT);
    waitDone("hold3");
    holdMode = 0;

    $display("[TB] second start mid-feed is ignored");
    applyStimulus(10'd0, 10'd100, N_OUT);
    repeat (20) @(negedge iClk);
    iStart  = 1'b1;
    iBaseRd = 10'd500;
    iBaseWr = 10'd700;
    @(negedge iClk);
    iStart = 1'b0;
    waitDone("restart_ignored");

    $display("[TB] reset at read 50, reset dominating start");
    d0 = doneCount;
    applyStimulus(10'd0, 10'd100, N_OUT);
    n = 0;
    while (readCount - rdStart < 50 && n < 500) begin
      @(negedge iClk);
      n++;
    end
    checkOutput("reached_read_50", 32'(readCount - rdStart >= 50), 32'd1);
    doReset(1'b1);
    checkOutput("no_done_on_abort", 32'(doneCount - d0), 32'd0);
    applyStimulus(10'd0, 10'd100, N_OUT);
    waitDone("after_abort");

    $display("[TB] partial pooler valids injected");
    junkEn   = 1'b1;
    holdMode = 2;
    applyStimulus(AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)), N_OUT);
    waitDone("junk_valid");
    junkEn = 1'b0;

    $display("[TB] random frames");
    for (int f = 0; f < 3; f++) begin
      applyStimulus(AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)), N_OUT);
      waitDone("random");
    end
    holdMode = 0;

    $display("[TB] pooler stalls after 20 results");
    stopAfter = 20;
    d0 = doneCount;
    e0 = errCount;
    applyStimulus(10'd0, 10'd100, 20);
    n = 0;
    while (rdQ.size() != 0 && n < 1000) begin
      @(negedge iClk);
      n++;
    end
    repeat (TIMEOUT + 30) @(negedge iClk);
    checkOutput("stall_writes", 32'(wrCount - wrStart), 32'd20);
    checkOutput("stall_no_done", 32'(doneCount - d0), 32'd0);
`ifdef POOL_CTRL_WATCHDOG_EN
    checkOutput("stall_err_pulse", 32'(errCount - e0), 32'd1);
    checkOutput("stall_idle", 32'(oBusy), 32'd0);
`else
    checkOutput("stall_no_err", 32'(errCount - e0), 32'd0);
    checkOutput("stall_still_busy", 32'(oBusy), 32'd1);
`endif
    doReset(1'b0);
    stopAfter = -1;

    applyStimulus(10'd1000, 10'd1010, N_OUT);
    waitDone("wrap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
